// File: rtl/cache_fill_responder.sv
// Word-addressed bus responder with configurable wait states and pipelined address/data phases.
// Optional out-of-range error response enabled by defining FILL_RESP_RANGE_ERR_EN.
module cache_fill_responder #(
  parameter int    ABITS      = 10,
  parameter int    FIRST_WAIT = 2,
  parameter int    SEQ_WAIT   = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HRequest,
  input  logic [31:0] HAddr,
  input  logic        HWrite,
  input  logic [31:0] HWData,
  output logic [31:0] HRData,
  output logic        HReady,
  output logic        HResp
);

  localparam int DEPTH = 1 << ABITS;

  if (FIRST_WAIT > 15 || SEQ_WAIT > 15) begin : g_bad_wait
    $error("cache_fill_responder: FIRST_WAIT/SEQ_WAIT must be 0..15");
  end

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t            state, state_nx;
  logic [3:0]        waitcnt, waitcnt_nx;
  logic [31:0]       cap_addr;
  logic              cap_write;
  logic [31:0]       mem [DEPTH];
  logic [ABITS-1:0]  idx, cap_idx;
  logic              accept, seq, range_err, fwd;
  logic [3:0]        wait_sel;

  assign idx     = HAddr[ABITS+1:2];
  assign cap_idx = cap_addr[ABITS+1:2];

  // Reset forces the idle-ready view even before the state register settles.
  assign HReady = reset | (state == IDLE) | (state == DATA) | (state == ERR2);
  assign accept = HRequest & HReady;

`ifdef FILL_RESP_RANGE_ERR_EN
  assign range_err = (HAddr >> (ABITS + 2)) != 32'd0;
  assign HResp     = ~reset & ((state == ERR1) | (state == ERR2));
`else
  assign range_err = 1'b0;
  assign HResp     = 1'b0;
`endif

  // Only a pipelined accept can be sequential; accepts from IDLE always start fresh.
  assign seq = ((state == DATA) || (state == ERR2)) && (HWrite == cap_write) &&
               (HAddr == cap_addr + 32'd4) && (HAddr[3:2] != 2'b00);
  assign wait_sel = seq ? 4'(SEQ_WAIT) : 4'(FIRST_WAIT);

  // Back-to-back write then read of the same word: hand the write data straight over.
  assign fwd = (state == DATA) && cap_write && (cap_idx == idx);

  always_comb begin
    state_nx   = state;
    waitcnt_nx = waitcnt;
    case (state)
      IDLE, DATA, ERR2: begin
        if (accept) begin
          if (range_err)            state_nx = ERR1;
          else if (wait_sel == 4'd0) state_nx = DATA;
          else begin
            state_nx   = WAIT;
            waitcnt_nx = wait_sel - 4'd1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (waitcnt == 4'd0) state_nx = DATA;
        else                 waitcnt_nx = waitcnt - 4'd1;
      end
      ERR1:    state_nx = ERR2;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitcnt   <= 4'd0;
      cap_addr  <= 32'd0;
      cap_write <= 1'b0;
      HRData    <= 32'd0;
    end else begin
      state   <= state_nx;
      waitcnt <= waitcnt_nx;
      if (accept) begin
        cap_addr  <= HAddr;
        cap_write <= HWrite;
      end
      if (state_nx == DATA) begin
        if (state == WAIT) begin
          if (!cap_write) HRData <= mem[cap_idx];
        end else if (!HWrite) begin
          HRData <= fwd ? HWData : mem[idx];
        end
      end else if (state_nx == ERR2) begin
        HRData <= 32'd0;
      end
    end
  end

  // Array is never reset; a write in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == DATA && cap_write)
      mem[cap_idx] <= HWData;
  end

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed self-checking bench for cache_fill_responder: one instance with FIRST_WAIT=2/SEQ_WAIT=0,
// one with FIRST_WAIT=0/SEQ_WAIT=1 for back-to-back forwarding and sequential-wait checks.
module tb_cache_fill_responder;

  logic        clk, reset;
  logic        HRequest, HWrite;
  logic [31:0] HAddr, HWData, HRData;
  logic        HReady, HResp;
  logic        zreq, zwr;
  logic [31:0] zaddr, zwdata, zrdata;
  logic        zready, zresp;
  int checks, failures;

  cache_fill_responder #(.ABITS(10), .FIRST_WAIT(2), .SEQ_WAIT(0)) dut (
    .clk(clk), .reset(reset), .HRequest(HRequest), .HAddr(HAddr), .HWrite(HWrite),
    .HWData(HWData), .HRData(HRData), .HReady(HReady), .HResp(HResp));

  cache_fill_responder #(.ABITS(10), .FIRST_WAIT(0), .SEQ_WAIT(1)) zdut (
    .clk(clk), .reset(reset), .HRequest(zreq), .HAddr(zaddr), .HWrite(zwr),
    .HWData(zwdata), .HRData(zrdata), .HReady(zready), .HResp(zresp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (HReady !== 1'b1 && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $error("FAIL %s observed=timeout expected=HReady", tag);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    HRequest = 1'b1; HAddr = a; HWrite = 1'b1;
    wait_ready("wr_acc"); tick();
    HRequest = 1'b0; HWData = d;
    wait_ready("wr_dat"); tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    HRequest = 1'b1; HAddr = a; HWrite = 1'b0;
    wait_ready("rd_acc"); tick();
    HRequest = 1'b0;
    wait_ready("rd_dat");
    chk(tag, HRData, exp);
    tick();
  endtask

  logic [31:0] a_tab [6];
  logic        r_tab [6];
  logic [31:0] d_tab [6];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; HRequest = 1'b0; HAddr = '0; HWrite = 1'b0; HWData = '0;
    zreq = 1'b0; zaddr = '0; zwr = 1'b0; zwdata = '0;

    // Reset: three cycles asserted plus the first released cycle.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset = 1'b0;
      tick();
      chk($sformatf("rst%0d_ready", i), {31'd0, HReady}, 32'd1);
      chk($sformatf("rst%0d_resp", i), {31'd0, HResp}, 32'd0);
      chk($sformatf("rst%0d_rdata", i), HRData, 32'd0);
    end

    // Preload
    for (int i = 0; i < 4; i++) wr(32'h40 + 32'(i * 4), 32'hA0A0_0000 + 32'(i));
    wr(32'h50, 32'hB0B0_B0B0);
    wr(32'h0, 32'hC0C0_C0C0);

    // Four-beat line fill 0x40..0x4C, request held through waits.
    a_tab = '{32'h44, 32'h44, 32'h44, 32'h48, 32'h4C, 32'h0};
    r_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    d_tab = '{32'h0, 32'h0, 32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
    chk("fill_idle_ready", {31'd0, HReady}, 32'd1);
    HRequest = 1'b1; HAddr = 32'h40; HWrite = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      HRequest = (c < 5); HAddr = a_tab[c];
      chk($sformatf("fill_c%0d_ready", c + 1), {31'd0, HReady}, {31'd0, r_tab[c]});
      if (r_tab[c]) chk($sformatf("fill_c%0d_rdata", c + 1), HRData, d_tab[c]);
      tick();
    end
    HRequest = 1'b0;
    tick();

    // Line wrap 0x4C -> 0x50: second beat is non-sequential.
    a_tab = '{32'h50, 32'h50, 32'h50, 32'h0, 32'h0, 32'h0};
    r_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    d_tab = '{32'h0, 32'h0, 32'hA0A0_0003, 32'h0, 32'h0, 32'hB0B0_B0B0};
    HRequest = 1'b1; HAddr = 32'h4C; HWrite = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      HRequest = (c < 3); HAddr = a_tab[c];
      chk($sformatf("wrap_c%0d_ready", c + 1), {31'd0, HReady}, {31'd0, r_tab[c]});
      if (r_tab[c]) chk($sformatf("wrap_c%0d_rdata", c + 1), HRData, d_tab[c]);
      tick();
    end
    HRequest = 1'b0;
    tick();

    // Reset during WAIT drops the beat; array keeps its contents.
    HRequest = 1'b1; HAddr = 32'h40; HWrite = 1'b0;
    tick();
    chk("rstw_wait_ready", {31'd0, HReady}, 32'd0);
    HRequest = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_after_ready", {31'd0, HReady}, 32'd1);
    tick();
    chk("rstw_idle_ready", {31'd0, HReady}, 32'd1);
    rd("rstw_data_intact", 32'h40, 32'hA0A0_0000);

`ifdef FILL_RESP_RANGE_ERR_EN
    HRequest = 1'b1; HAddr = 32'h0000_1000; HWrite = 1'b0;
    tick();
    HRequest = 1'b0;
    chk("rerr_c1_ready", {31'd0, HReady}, 32'd0);
    chk("rerr_c1_resp", {31'd0, HResp}, 32'd1);
    tick();
    chk("rerr_c2_ready", {31'd0, HReady}, 32'd1);
    chk("rerr_c2_resp", {31'd0, HResp}, 32'd1);
    chk("rerr_c2_rdata", HRData, 32'd0);
    tick();
    chk("rerr_idle_resp", {31'd0, HResp}, 32'd0);
    wr(32'h0000_1000, 32'h1234_5678);
    rd("rerr_wr_dropped", 32'h0, 32'hC0C0_C0C0);
`else
    rd("alias_rd_1000", 32'h0000_1000, 32'hC0C0_C0C0);
    chk("alias_resp", {31'd0, HResp}, 32'd0);
`endif

    // Zero-wait instance: write then read same word back-to-back.
    zreq = 1'b1; zaddr = 32'h100; zwr = 1'b1;
    tick();
    chk("raw_wr_ready", {31'd0, zready}, 32'd1);
    zwdata = 32'hDEAD_BEEF; zwr = 1'b0;
    tick();
    zreq = 1'b0;
    chk("raw_rd_ready", {31'd0, zready}, 32'd1);
    chk("raw_rd_rdata", zrdata, 32'hDEAD_BEEF);
    tick();

    // Sequential read 0x100 -> 0x104 picks up SEQ_WAIT=1.
    zwr = 1'b1; zreq = 1'b1; zaddr = 32'h104;
    tick();
    zwdata = 32'h0104_0104; zreq = 1'b0;
    tick();
    zreq = 1'b1; zaddr = 32'h100; zwr = 1'b0;
    tick();
    chk("seq_c1_ready", {31'd0, zready}, 32'd1);
    chk("seq_c1_rdata", zrdata, 32'hDEAD_BEEF);
    zaddr = 32'h104;
    tick();
    zreq = 1'b0;
    chk("seq_c2_ready", {31'd0, zready}, 32'd0);
    tick();
    chk("seq_c3_ready", {31'd0, zready}, 32'd1);
    chk("seq_c3_rdata", zrdata, 32'h0104_0104);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
